// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter. It sends one strobe per frame and
// re-strobes the head byte until the UART reports busy, so bytes are neither lost nor duplicated.
module uart_tx_buffer #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned RETRY_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic                  transmit_o,
  output logic [7:0]            tx_byte_o,
  input  logic                  is_transmitting_i
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned RetryW = (RETRY_CYCLES < 2) ? 1 : $clog2(RETRY_CYCLES + 1);
  localparam logic [DEPTH_LOG2:0] DepthCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [RetryW-1:0]   RetryMax   = RetryW'(RETRY_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone
  } state_e;

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  transmit_q, transmit_d;
  logic [RetryW-1:0]     retry_q, retry_d;
  state_e                state_q, state_d;

  logic full, empty, push, pop;

  assign full  = (count_q == DepthCount);
  assign empty = (count_q == '0);

  // A pop while full does not make room for a same-cycle push.
  assign push = wr_en_i & ~full & ~flush_i;
  assign pop  = (state_q == StWaitBusy) & is_transmitting_i & ~flush_i;

  assign overflow_d = wr_en_i & full & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      StIdle: begin
        if (!empty && !flush_i) state_d = StLaunch;
      end
      StLaunch: begin
        retry_d = '0;
        state_d = flush_i ? StIdle : StWaitBusy;
      end
      StWaitBusy: begin
        if (flush_i) begin
          state_d = StIdle;
          retry_d = '0;
        end else if (is_transmitting_i) begin
          state_d = StWaitDone;
        end else begin
          // UART ignored the strobe (e.g. still in its own reset); strobe the same head again.
          retry_d = retry_q + 1'b1;
          if (retry_d == RetryMax) state_d = StLaunch;
        end
      end
      StWaitDone: begin
        // A flush here leaves the byte already on the line to finish.
        if (!is_transmitting_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign transmit_d = (state_d == StLaunch);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      retry_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      transmit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      transmit_q <= transmit_d;
    end
  end

  // Storage is cleared on reset so tx_byte_o is never X at the UART.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign transmit_o = transmit_q;
  assign tx_byte_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: a per-cycle vector table plus hand sequences for
// back-to-back traffic, overflow, and reset in the middle of a frame.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full, empty, overflow, transmit;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       is_tx;
  logic       is_tx_man;
  logic       uart_auto;
  int unsigned busy_cnt;

  int tests  = 0;
  int failed = 0;

  uart_tx_buffer #(
    .DEPTH_LOG2   (4),
    .RETRY_CYCLES (2)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .wr_en_i           (wr_en),
    .wr_data_i         (wr_data),
    .flush_i           (flush),
    .full_o            (full),
    .empty_o           (empty),
    .count_o           (count),
    .overflow_o        (overflow),
    .transmit_o        (transmit),
    .tx_byte_o         (tx_byte),
    .is_transmitting_i (is_tx)
  );

  always #5 clk = ~clk;

  // UART model: a strobe seen at an edge makes it busy for the next 40 cycles.
  always @(posedge clk) begin
    if (!uart_auto)        busy_cnt <= 0;
    else if (transmit)     busy_cnt <= 40;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign is_tx = uart_auto ? (busy_cnt != 0) : is_tx_man;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       is_tx;
    logic       exp_tx;
    logic [7:0] exp_byte;
    logic       chk_byte;
    logic [4:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic [7:0] d, input logic f, input logic b,
                     input logic et, input logic [7:0] eb, input logic cb,
                     input logic [4:0] ec, input logic eo);
    vec_t v;
    v.wr_en = w; v.wr_data = d; v.flush = f; v.is_tx = b;
    v.exp_tx = et; v.exp_byte = eb; v.chk_byte = cb; v.exp_count = ec; v.exp_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes_seen[$];
    int         strobe_cyc[$];
    logic [4:0] trace[$];
    logic [4:0] exp_trace[6];
    logic [4:0] last_count;
    logic       prev_busy;
    int         last_fall;
    int         got;

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
    is_tx_man = 1'b0; uart_auto = 1'b0;

    // Single byte 0x55, clean handshake.
    add(1, 8'h55, 0, 0,  0, 8'h55, 1, 1, 0);
    add(0, 8'h00, 0, 0,  1, 8'h55, 1, 1, 0);
    add(0, 8'h00, 0, 0,  0, 8'h55, 1, 1, 0);
    add(0, 8'h00, 0, 1,  0, 8'h00, 1, 0, 0);
    add(0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);
    // Four bytes queued, retry, then flush during LAUNCH.
    add(1, 8'hA1, 0, 0,  0, 8'hA1, 1, 1, 0);
    add(1, 8'hA2, 0, 0,  1, 8'hA1, 1, 2, 0);
    add(1, 8'hA3, 0, 0,  0, 8'hA1, 1, 3, 0);
    add(1, 8'hA4, 0, 0,  0, 8'hA1, 1, 4, 0);
    add(0, 8'h00, 0, 0,  1, 8'hA1, 1, 4, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);
    // Ignored strobe on 0x7E, then flush during WAIT_DONE.
    add(1, 8'h7E, 0, 0,  0, 8'h7E, 1, 1, 0);
    add(0, 8'h00, 0, 0,  1, 8'h7E, 1, 1, 0);
    add(0, 8'h00, 0, 0,  0, 8'h7E, 1, 1, 0);
    add(0, 8'h00, 0, 0,  0, 8'h7E, 1, 1, 0);
    add(0, 8'h00, 0, 0,  1, 8'h7E, 1, 1, 0);
    add(0, 8'h00, 0, 0,  0, 8'h7E, 1, 1, 0);
    add(0, 8'h00, 0, 1,  0, 8'hA1, 1, 0, 0);
    add(1, 8'hB1, 0, 1,  0, 8'hB1, 1, 1, 0);
    add(1, 8'hEE, 1, 1,  0, 8'h7E, 1, 0, 0);
    add(1, 8'hC1, 0, 1,  0, 8'hC1, 1, 1, 0);
    add(0, 8'h00, 0, 1,  0, 8'hC1, 1, 1, 0);
    add(0, 8'h00, 0, 0,  0, 8'hC1, 1, 1, 0);
    add(0, 8'h00, 0, 0,  1, 8'hC1, 1, 1, 0);
    add(0, 8'h00, 0, 1,  0, 8'hC1, 1, 1, 0);
    add(0, 8'h00, 0, 1,  0, 8'hB1, 1, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);

    #2;
    check("reset count", count, 0);
    check("reset empty", empty, 1);
    check("reset full", full, 0);
    check("reset overflow", overflow, 0);
    check("reset transmit", transmit, 0);
    check("reset tx_byte", tx_byte, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
      flush = vecs[i].flush; is_tx_man = vecs[i].is_tx;
      step();
      check($sformatf("v%0d transmit", i), transmit, vecs[i].exp_tx);
      check($sformatf("v%0d count", i), count, vecs[i].exp_count);
      check($sformatf("v%0d empty", i), empty, vecs[i].exp_count == 0);
      check($sformatf("v%0d full", i), full, vecs[i].exp_count == 16);
      check($sformatf("v%0d overflow", i), overflow, vecs[i].exp_ovf);
      if (vecs[i].chk_byte) check($sformatf("v%0d tx_byte", i), tx_byte, vecs[i].exp_byte);
    end
    wr_en = 1'b0; flush = 1'b0; is_tx_man = 1'b0;

    // Back-to-back 0x01..0x03 against a UART busy 40 cycles per byte.
    uart_auto = 1'b1;
    last_count = count;
    prev_busy = 1'b0;
    last_fall = -100;
    for (int cyc = 0; cyc < 200; cyc++) begin
      wr_en = (cyc < 3);
      wr_data = 8'(cyc + 1);
      step();
      if (prev_busy && !is_tx) last_fall = cyc;
      prev_busy = is_tx;
      if (transmit) begin
        bytes_seen.push_back(tx_byte);
        strobe_cyc.push_back(cyc - last_fall);
      end
      if (count != last_count) begin
        trace.push_back(count);
        last_count = count;
      end
    end
    wr_en = 1'b0;
    check("b2b strobes", bytes_seen.size(), 3);
    foreach (bytes_seen[k]) begin
      check($sformatf("b2b byte%0d", k), bytes_seen[k], 8'(k + 1));
      if (k > 0) check($sformatf("b2b relaunch gap%0d", k), strobe_cyc[k], 2);
    end
    exp_trace = '{5'd1, 5'd2, 5'd3, 5'd2, 5'd1, 5'd0};
    check("b2b count trace length", trace.size(), 6);
    foreach (trace[k]) if (k < 6) check($sformatf("b2b count trace%0d", k), trace[k], exp_trace[k]);

    // Fill to full with the UART idle, then overflow with 0xAA.
    uart_auto = 1'b0;
    is_tx_man = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + k);
      step();
    end
    check("fill count", count, 16);
    check("fill full", full, 1);
    check("fill empty", empty, 0);
    check("fill overflow idle", overflow, 0);
    wr_data = 8'hAA;
    step();
    check("ovf pulse", overflow, 1);
    check("ovf count", count, 16);
    check("ovf full", full, 1);
    wr_en = 1'b0;
    step();
    check("ovf pulse ends", overflow, 0);
    check("ovf count held", count, 16);
    check("ovf head", tx_byte, 8'h10);

    bytes_seen.delete();
    uart_auto = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (transmit) bytes_seen.push_back(tx_byte);
      if (bytes_seen.size() == 16 && empty) break;
      step();
    end
    check("drain strobes", bytes_seen.size(), 16);
    check("drain count", count, 0);
    foreach (bytes_seen[k]) check($sformatf("drain byte%0d", k), bytes_seen[k], 8'(8'h10 + k));
    uart_auto = 1'b0;

    // Asynchronous reset while in WAIT_DONE with five bytes still queued.
    is_tx_man = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + k);
      step();
    end
    wr_en = 1'b0;
    is_tx_man = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (count == 5) begin
        got = 1;
        break;
      end
    end
    check("midframe reached count 5", got, 1);
    step();
    check("midframe count held", count, 5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst count", count, 0);
    check("async rst empty", empty, 1);
    check("async rst full", full, 0);
    check("async rst overflow", overflow, 0);
    check("async rst transmit", transmit, 0);
    check("async rst tx_byte", tx_byte, 0);
    @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 2) is_tx_man = 1'b0;
      step();
      if (transmit) got++;
    end
    check("post-reset strobes", got, 0);
    check("post-reset count", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
